// File: rtl/pwm_duty_capture_pkg.sv
// Shared LED-subsystem definitions used by the PWM generators and the
// duty-capture receiver.
//   PWM_PERIOD : nominal period of the free-running 8-bit PWM, in clk cycles
//   DUTY_W     : width of a duty value
//   ST_*       : duty-capture FSM encoding
//   sample_t   : one published measurement (duty, period_err, stuck)
//   sat_duty() : clamp a high-cycle count to the duty range
package pwm_duty_capture_pkg;

    localparam int PWM_PERIOD = 256;
    localparam int DUTY_W     = 8;

    localparam logic [DUTY_W-1:0] DUTY_MAX = '1;

    localparam logic [1:0] ST_WAIT_FIRST = 2'd0;
    localparam logic [1:0] ST_MEASURE    = 2'd1;
    localparam logic [1:0] ST_STUCK      = 2'd2;

    typedef struct packed {
        logic [DUTY_W-1:0] duty;
        logic              period_err;
        logic              stuck;
    } sample_t;

    function automatic logic [DUTY_W-1:0] sat_duty(input logic [31:0] cnt);
        if (cnt > 32'(DUTY_MAX)) begin
            return DUTY_MAX;
        end
        return cnt[DUTY_W-1:0];
    endfunction

endpackage

// File: rtl/pwm_duty_capture_sync_edge_det.sv
// Multi-flop synchroniser with rising-edge detect for an asynchronous
// single-bit input (PWM lines, buttons, switches).
//   clk  : system clock
//   rst  : asynchronous reset, active low; clears the chain to 0
//   din  : asynchronous input
//   dout : synchronised level (last flop of the chain)
//   rise : one-cycle pulse, dout is 1 and was 0 the previous cycle
// SYNC_STAGES must be at least 2.
module sync_edge_det #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   dly_q, dly_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], din};
        dly_d  = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
            dly_q  <= 1'b0;
        end else begin
            sync_q <= sync_d;
            dly_q  <= dly_d;
        end
    end

    assign dout = sync_q[SYNC_STAGES-1];
    // Because the chain clears to 0, a line already high at reset release
    // shows up as one rise.
    assign rise = sync_q[SYNC_STAGES-1] & ~dly_q;

endmodule

// File: rtl/pwm_duty_capture.sv
// Recovers the duty value of an external PWM waveform once per period.
//   clk        : system clock
//   rst        : asynchronous reset, active low
//   pwm_in     : asynchronous PWM input
//   duty       : last recovered duty (high cycles per period, saturated)
//   duty_valid : one-cycle pulse when duty/period_err/stuck update
//   period_err : measured period differed from PERIOD (always 1 when stuck)
//   stuck      : no rising edge for 2*PERIOD cycles; duty = line level
// Periods are delimited by rising edges only. The first rise after reset or
// after a stuck episode only arms measurement; samples start at the second.
module pwm_duty_capture
    import pwm_duty_capture_pkg::*;
#(
    parameter int PERIOD      = PWM_PERIOD,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pwm_in,
    output logic [DUTY_W-1:0] duty,
    output logic              duty_valid,
    output logic              period_err,
    output logic              stuck
);

    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_PERIOD = CNT_W'(PERIOD);
    localparam logic [CNT_W-1:0] CNT_TMO    = CNT_W'(2 * PERIOD);
    localparam logic [CNT_W-1:0] CNT_TMO_M1 = CNT_W'(2 * PERIOD - 1);
    localparam logic [CNT_W-1:0] REP_LAST   = CNT_W'(PERIOD - 1);

    logic pwm_s, rise, timeout;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] period_cnt_q, period_cnt_d;
    logic [CNT_W-1:0] high_cnt_q, high_cnt_d;
    logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
    sample_t          sample_q, sample_d;
    logic             valid_q, valid_d;
    sample_t          stuck_sample;

    sync_edge_det #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .din (pwm_in),
        .dout(pwm_s),
        .rise(rise)
    );

    // Period / high-time counters, restarted by every rise.
    always_comb begin
        period_cnt_d = period_cnt_q;
        high_cnt_d   = high_cnt_q;
        if (rise) begin
            period_cnt_d = CNT_ONE;
            high_cnt_d   = CNT_ONE;
        end else begin
            if (period_cnt_q != CNT_TMO) begin
                period_cnt_d = period_cnt_q + CNT_ONE;
            end
            if (pwm_s && (high_cnt_q != CNT_TMO)) begin
                high_cnt_d = high_cnt_q + CNT_ONE;
            end
        end
    end

    // Fires on the edge where period_cnt would step onto 2*PERIOD; a
    // simultaneous rise takes priority.
    assign timeout = ~rise & (period_cnt_q == CNT_TMO_M1);

    always_comb begin
        stuck_sample.duty       = pwm_s ? DUTY_MAX : '0;
        stuck_sample.period_err = 1'b1;
        stuck_sample.stuck      = 1'b1;
    end

    always_comb begin
        state_d   = state_q;
        sample_d  = sample_q;
        valid_d   = 1'b0;
        rep_cnt_d = '0;
        case (state_q)
            ST_WAIT_FIRST: begin
                if (rise) begin
                    state_d = ST_MEASURE;
                end else if (timeout) begin
                    sample_d = stuck_sample;
                    valid_d  = 1'b1;
                    state_d  = ST_STUCK;
                end
            end
            ST_MEASURE: begin
                if (rise) begin
                    sample_d.duty       = sat_duty(32'(high_cnt_q));
                    sample_d.period_err = (period_cnt_q != CNT_PERIOD);
                    sample_d.stuck      = 1'b0;
                    valid_d             = 1'b1;
                end else if (timeout) begin
                    sample_d = stuck_sample;
                    valid_d  = 1'b1;
                    state_d  = ST_STUCK;
                end
            end
            ST_STUCK: begin
                // period_cnt is parked at saturation here, so a separate
                // counter paces the periodic stuck reports.
                if (rise) begin
                    state_d = ST_MEASURE;
                end else if (rep_cnt_q == REP_LAST) begin
                    sample_d = stuck_sample;
                    valid_d  = 1'b1;
                end else begin
                    rep_cnt_d = rep_cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_WAIT_FIRST;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_WAIT_FIRST;
            period_cnt_q <= '0;
            high_cnt_q   <= '0;
            rep_cnt_q    <= '0;
            sample_q     <= '0;
            valid_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            period_cnt_q <= period_cnt_d;
            high_cnt_q   <= high_cnt_d;
            rep_cnt_q    <= rep_cnt_d;
            sample_q     <= sample_d;
            valid_q      <= valid_d;
        end
    end

    assign duty       = sample_q.duty;
    assign period_err = sample_q.period_err;
    assign stuck      = sample_q.stuck;
    assign duty_valid = valid_q;

endmodule

// File: tb/tb_pwm_duty_capture.sv
// Directed bench for pwm_duty_capture: stimulus pushes hand-computed
// samples into a queue, a monitor pops and compares on every duty_valid.
module tb_pwm_duty_capture;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       pwm_in = 1'b0;
    logic [7:0] duty;
    logic       duty_valid, period_err, stuck;

    pwm_duty_capture #(
        .PERIOD(256),
        .SYNC_STAGES(2),
        .CNT_W(10)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pwm_in    (pwm_in),
        .duty      (duty),
        .duty_valid(duty_valid),
        .period_err(period_err),
        .stuck     (stuck)
    );

    always #5 clk = ~clk;

    typedef struct {
        int duty;
        bit perr;
        bit stk;
        int gap;   // cycles since previous pulse, 0 = not checked
    } exp_t;

    exp_t exp_q[$];
    int   pass_cnt = 0;
    int   tot_cnt  = 0;
    int   cyc      = 0;
    int   last_cyc = 0;
    int   smp_idx  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int expv);
        tot_cnt++;
        if (act == expv) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, act, expv);
    endtask

    task automatic push(input int d, input bit pe, input bit st, input int gap);
        exp_t e;
        e.duty = d; e.perr = pe; e.stk = st; e.gap = gap;
        exp_q.push_back(e);
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (rst && duty_valid) begin
            if (exp_q.size() == 0) begin
                tot_cnt++;
                $display("FAIL unexpected_valid at cycle %0d: duty=%0d err=%0b stuck=%0b",
                         cyc, duty, period_err, stuck);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                tot_cnt++;
                if (duty == e.duty[7:0] && period_err == e.perr && stuck == e.stk) pass_cnt++;
                else $display("FAIL sample%0d: got duty=%0d err=%0b stuck=%0b, expected duty=%0d err=%0b stuck=%0b",
                              smp_idx, duty, period_err, stuck, e.duty, e.perr, e.stk);
                if (e.gap != 0) chk($sformatf("sample%0d_gap", smp_idx), cyc - last_cyc, e.gap);
                smp_idx++;
            end
            last_cyc = cyc;
        end
    end

    // Level held for n sampling edges, transitions on the falling edge.
    task automatic drv(input bit v, input int n);
        pwm_in = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic per(input int hi, input int lo);
        drv(1'b1, hi);
        drv(1'b0, lo);
    endtask

    // Same, but transitions 3 ns after the rising edge.
    task automatic drv_j(input bit v, input int n);
        pwm_in = v;
        repeat (n) @(posedge clk);
        #3;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_duty"}, duty, 0);
        chk({tag, "_valid"}, duty_valid, 0);
        chk({tag, "_perr"}, period_err, 0);
        chk({tag, "_stuck"}, stuck, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk_reset("por");
        rst = 1'b1;

        // Line low from reset: stuck at ~512, republished 256 later.
        push(0, 1, 1, 0);
        push(0, 1, 1, 256);
        drv(1'b0, 800);

        // Line high: first rise only arms, then stuck-high reports.
        push(255, 1, 1, 0);
        push(255, 1, 1, 256);
        drv(1'b1, 800);
        drv(1'b0, 128);

        // Ideal duty 128: first rise arms, samples every 256.
        per(128, 128);
        push(128, 0, 0, 0);   per(128, 128);
        push(128, 0, 0, 256); per(128, 128);
        push(128, 0, 0, 256); per(128, 128);

        // Duty 255 then duty 1.
        push(128, 0, 0, 256); per(255, 1);
        push(255, 0, 0, 256); per(1, 255);

        // 64 -> 192 at a period boundary.
        push(1, 0, 0, 256);   per(64, 192);
        push(64, 0, 0, 256);  per(192, 64);

        // Period 300 with 100 high, then a 1-cycle glitch mid-low.
        push(192, 0, 0, 256); per(100, 200);
        push(100, 1, 0, 300);
        push(100, 1, 0, 150);
        drv(1'b1, 100); drv(1'b0, 50); drv(1'b1, 1); drv(1'b0, 105);

        // Stuck episode then resumed PWM.
        push(1, 1, 0, 106);
        push(0, 1, 1, 0);
        push(0, 1, 1, 256);
        per(128, 700);
        per(128, 128);
        push(128, 0, 0, 0);   per(128, 128);
        push(128, 0, 0, 256); per(128, 128);

        // Reset mid-period with jittered input.
        push(128, 0, 0, 256);
        drv(1'b1, 128); drv(1'b0, 60);
        @(posedge clk); #3;
        rst = 1'b0;
        #1;
        chk_reset("mid_rst");
        #3 pwm_in = 1'b1;
        #4 pwm_in = 1'b0;
        #7 pwm_in = 1'b1;
        #6 pwm_in = 1'b0;
        repeat (5) @(negedge clk);
        chk_reset("in_rst");
        @(posedge clk); #6;
        rst = 1'b1;
        @(posedge clk); #3;
        drv_j(1'b0, 50);
        drv_j(1'b1, 128); drv_j(1'b0, 128);
        push(128, 0, 0, 0);
        drv_j(1'b1, 128); drv_j(1'b0, 128);
        push(128, 0, 0, 256);
        drv_j(1'b1, 128); drv_j(1'b0, 40);

        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
        repeat (5) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
